// File: rtl/aes128_key_sched_pkg.sv
// Shared AES-128 definitions: round count, round-constant seed, byte/word/state
// types, the key-schedule FSM states and the GF(2^8) doubling helper.
package aes128_key_sched_pkg;

    localparam logic [3:0] NR        = 4'd10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef logic [7:0]   aes_byte_t;
    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_state_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ks_state_t;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1; also serves MixColumns m02.
    function automatic aes_byte_t xtime(input aes_byte_t x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes128_key_sched_if.sv
// Start/key load and round-key valid/ready handshake between the key schedule
// and its consumer (AddRoundKey).
interface aes128_key_sched_if;
    import aes128_key_sched_pkg::*;

    logic       start;
    aes_state_t key_in;
    logic       busy;
    logic       rk_valid;
    logic       rk_ready;
    aes_state_t rk;
    logic [3:0] rk_idx;
    logic       done;

    modport master (
        output start, key_in, rk_ready,
        input  busy, rk_valid, rk, rk_idx, done
    );

    modport slave (
        input  start, key_in, rk_ready,
        output busy, rk_valid, rk, rk_idx, done
    );

endinterface

// File: rtl/aes128_key_sched_sbox.sv
// Combinational FIPS-197 forward S-box, one byte in, one byte out.
// Used four times for SubWord here and reusable for SubBytes.
module aes128_key_sched_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = SBOX[a];

endmodule

// File: rtl/aes128_key_sched.sv
// Iterative AES-128 key expansion: loads the cipher key as round key 0 and
// produces one further round key per accepted valid/ready handshake, up to 10.
module aes128_key_sched
    import aes128_key_sched_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    aes128_key_sched_if.slave bus
);

    ks_state_t  state_q, state_d;
    logic       load, adv, fin;
    aes_state_t rk_q, rk_nxt;
    logic [3:0] rk_idx_q;
    aes_byte_t  rcon_q;
    logic       done_q;

    aes_word_t  w0, w1, w2, w3;
    aes_word_t  rot, sub, t;
    aes_word_t  n0, n1, n2, n3;

    // Column c of the state is word wc; row 0 sits in the low byte.
    assign w0  = rk_q[31:0];
    assign w1  = rk_q[63:32];
    assign w2  = rk_q[95:64];
    assign w3  = rk_q[127:96];
    assign rot = {w3[7:0], w3[31:8]};

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes128_key_sched_sbox u_sbox (
            .a (rot[8*i +: 8]),
            .y (sub[8*i +: 8])
        );
    end

    // Round constant only touches row 0 of the rotated, substituted word.
    assign t      = sub ^ {24'h0, rcon_q};
    assign n0     = w0 ^ t;
    assign n1     = w1 ^ n0;
    assign n2     = w2 ^ n1;
    assign n3     = w3 ^ n2;
    assign rk_nxt = {n3, n2, n1, n0};

    // Next-state decode: load on start in IDLE, advance or finish on a handshake in RUN.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        adv     = 1'b0;
        fin     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // rk_valid is high throughout RUN, so rk_ready alone marks a handshake.
                if (bus.rk_ready) begin
                    if (rk_idx_q == NR) begin
                        fin     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Round key, index, round constant and done pulse; all hold when no strobe fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_q     <= '0;
            rk_idx_q <= 4'd0;
            rcon_q   <= RCON_INIT;
            done_q   <= 1'b0;
        end else begin
            done_q <= fin;
            if (load) begin
                rk_q     <= bus.key_in;
                rk_idx_q <= 4'd0;
                rcon_q   <= RCON_INIT;
            end else if (adv) begin
                rk_q     <= rk_nxt;
                rk_idx_q <= rk_idx_q + 4'd1;
                rcon_q   <= xtime(rcon_q);
            end
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.rk_valid = (state_q == RUN);
    assign bus.rk       = rk_q;
    assign bus.rk_idx   = rk_idx_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_aes128_key_sched.sv
// Bench for aes128_key_sched: directed FIPS-197 vectors plus random keys,
// random backpressure and stray start pulses, against a byte-level model that
// derives the S-box from GF(2^8) inversion and the affine map.
module tb_aes128_key_sched;

    localparam logic [127:0] KEY_A1  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    localparam logic [127:0] A1_RK1  = 128'h05766c2a3939a323b12c548817fefaa0;
    localparam logic [127:0] A1_RK10 = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
    localparam logic [127:0] ZK_RK1  = 128'h63636362636363626363636263636362;

    logic clk;
    logic rst_n;

    aes128_key_sched_if bus ();

    aes128_key_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           tests;
    int           fails;
    int           last_cycles;
    logic [127:0] exp_rk [11];
    logic [127:0] obs_rk [11];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse (x^254) then affine transform.
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] b;
        b = 8'h01;
        for (int i = 0; i < 254; i++) b = gmul(b, x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // FIPS-197 KeyExpansion over byte arrays, then packed into 11 round keys.
    function automatic void expand(input logic [127:0] key);
        logic [7:0] w   [44][4];
        logic [7:0] tmp [4];
        logic [7:0] rc;
        logic [7:0] t0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                w[i][j] = key[8*(4*i+j) +: 8];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
            if (i % 4 == 0) begin
                t0     = tmp[0];
                tmp[0] = sbox_ref(tmp[1]) ^ rc;
                tmp[1] = sbox_ref(tmp[2]);
                tmp[2] = sbox_ref(tmp[3]);
                tmp[3] = sbox_ref(t0);
                rc     = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
        end
        for (int r = 0; r < 11; r++)
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++)
                    exp_rk[r][8*(4*c+j) +: 8] = w[4*r+c][j];
    endfunction

    // One full expansion with rk_ready asserted ready_pct percent of cycles;
    // noise adds start pulses with unrelated keys while the engine is busy.
    task automatic run_keys(input logic [127:0] key, input int ready_pct, input bit noise);
        int idx;
        int done_cnt;
        int cyc;
        bit exp_done;
        bit finished;
        bit rdy;
        expand(key);
        bus.key_in   = key;
        bus.start    = 1'b1;
        bus.rk_ready = 1'b0;
        chk("busy_before_start", 128'(bus.busy), 128'(0));
        @(posedge clk); #1;
        bus.start = 1'b0;
        idx = 0; done_cnt = 0; cyc = 0; exp_done = 1'b0; finished = 1'b0;
        while (!finished && cyc < 400) begin
            if (bus.done) done_cnt++;
            chk("done", 128'(bus.done), 128'(exp_done));
            if (exp_done) begin
                chk("busy_end", 128'(bus.busy), 128'(0));
                chk("valid_end", 128'(bus.rk_valid), 128'(0));
                chk("idx_end", 128'(bus.rk_idx), 128'(10));
                chk("rk_end", bus.rk, exp_rk[10]);
                last_cycles  = cyc;
                finished     = 1'b1;
                bus.start    = 1'b0;
                bus.rk_ready = 1'b0;
            end else begin
                chk("rk_valid", 128'(bus.rk_valid), 128'(1));
                chk("busy", 128'(bus.busy), 128'(1));
                chk("rk_idx", 128'(bus.rk_idx), 128'(idx));
                chk("rk", bus.rk, exp_rk[idx]);
                obs_rk[idx] = bus.rk;
                rdy = (ready_pct >= 100) || ($urandom_range(99) < ready_pct);
                bus.rk_ready = rdy;
                if (noise) begin
                    bus.start  = ($urandom_range(1) == 1);
                    bus.key_in = {$urandom, $urandom, $urandom, $urandom};
                end
                if (rdy) begin
                    if (idx == 10) exp_done = 1'b1;
                    else idx++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("finished", 128'(finished), 128'(1));
        if (bus.done) done_cnt++;
        chk("done_after", 128'(bus.done), 128'(0));
        chk("busy_after", 128'(bus.busy), 128'(0));
        chk("done_count", 128'(done_cnt), 128'(1));
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        last_cycles  = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.key_in   = '0;
        bus.rk_ready = 1'b0;

        // Reset, then idle outputs for five cycles.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("idle_busy", 128'(bus.busy), 128'(0));
            chk("idle_valid", 128'(bus.rk_valid), 128'(0));
            chk("idle_done", 128'(bus.done), 128'(0));
            chk("idle_rk", bus.rk, 128'(0));
            chk("idle_idx", 128'(bus.rk_idx), 128'(0));
        end

        // FIPS-197 A.1 at full throughput.
        run_keys(KEY_A1, 100, 1'b0);
        chk("a1_done_latency", 128'(last_cycles), 128'(11));
        chk("a1_rk0", obs_rk[0], KEY_A1);
        chk("a1_rk1", obs_rk[1], A1_RK1);
        chk("a1_rk10", obs_rk[10], A1_RK10);

        // Same key under 30% ready backpressure.
        run_keys(KEY_A1, 30, 1'b0);
        chk("bp_rk1", obs_rk[1], A1_RK1);
        chk("bp_rk10", obs_rk[10], A1_RK10);

        // Stray start pulses with other keys while busy.
        run_keys(KEY_A1, 70, 1'b1);
        chk("noise_rk0", obs_rk[0], KEY_A1);
        chk("noise_rk1", obs_rk[1], A1_RK1);
        chk("noise_rk10", obs_rk[10], A1_RK10);

        // Asynchronous reset in the middle of an expansion.
        expand(KEY_A1);
        bus.key_in   = KEY_A1;
        bus.start    = 1'b1;
        bus.rk_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("mid_idx", 128'(bus.rk_idx), 128'(5));
        chk("mid_rk", bus.rk, exp_rk[5]);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 128'(bus.busy), 128'(0));
        chk("arst_valid", 128'(bus.rk_valid), 128'(0));
        chk("arst_done", 128'(bus.done), 128'(0));
        chk("arst_rk", bus.rk, 128'(0));
        chk("arst_idx", 128'(bus.rk_idx), 128'(0));
        @(posedge clk); #1;
        chk("arst_hold_busy", 128'(bus.busy), 128'(0));
        bus.rk_ready = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", 128'(bus.busy), 128'(0));
        run_keys({$urandom, $urandom, $urandom, $urandom}, 100, 1'b0);

        // All-zero key.
        run_keys(128'(0), 100, 1'b0);
        chk("zero_rk1", obs_rk[1], ZK_RK1);

        // Random keys, random backpressure, random stray starts.
        for (int k = 0; k < 4; k++) begin
            run_keys({$urandom, $urandom, $urandom, $urandom}, 20 + $urandom_range(80), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
